// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480@60 VGA scan generator.
// Default PIPE_LAT matches the address-generator -> BRAM -> colour latency.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;
   localparam int H_TOTAL_DEF  = 800;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;
   localparam int V_TOTAL_DEF  = 525;

   localparam int PIPE_LAT_DEF = 3;

   // Both syncs are active-low for this mode.
   localparam logic SYNC_ACTIVE = 1'b0;

   typedef struct packed {
      logic valid;
      logic hsync;
      logic vsync;
   } scan_sig_t;

   localparam scan_sig_t SCAN_IDLE = '{valid: 1'b0, hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE};

   function automatic logic in_win(input logic [9:0] val, input logic [9:0] lo, input logic [9:0] hi);
      return (val >= lo) && (val < hi);
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Tick-enabled shift register used to realign sync/valid with the BRAM colour path.
// Every stage resets asynchronously to RST_VAL.
module sync_delay_line #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
         stage[0] <= d;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster timing master: pixel divider, h/v counters, syncs, valid, strobes, frame counter.
// Build option VGA_SYNC_ALIGN_EN delays hsync/vsync/valid by PIPE_LAT pixel ticks.
module vga_scan_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 1,
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter int PIPE_LAT = PIPE_LAT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       pix_tick,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   if (CLK_DIV < 1 || PIPE_LAT < 1) begin : g_bad_param
      $error("vga_scan_gen: CLK_DIV and PIPE_LAT must both be at least 1");
   end

   if (CLK_DIV > 1) begin : g_div
      localparam int              DIV_W    = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
      logic [DIV_W-1:0] div_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                  div_cnt <= '0;
         else if (div_cnt == DIV_LAST) div_cnt <= '0;
         else                         div_cnt <= div_cnt + DIV_W'(1);
      end

      assign pix_tick = (div_cnt == DIV_LAST);
   end else begin : g_no_div
      assign pix_tick = 1'b1;
   end

   logic       h_wrap;
   logic       v_wrap;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   scan_sig_t  scan_nxt;
   scan_sig_t  scan_r;

   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);
      h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
      v_nxt  = v_cnt;
      if (h_wrap) v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
      // Decode the post-update position so the flags land in the same register stage as the counters.
      scan_nxt.valid = (h_nxt < H_ACT) && (v_nxt < V_ACT);
      scan_nxt.hsync = in_win(h_nxt, HS_BEG, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      scan_nxt.vsync = in_win(v_nxt, VS_BEG, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_cnt   <= '0;
         scan_r      <= SCAN_IDLE;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_tick && h_wrap;
         frame_start <= pix_tick && h_wrap && v_wrap;
         if (pix_tick) begin
            h_cnt  <= h_nxt;
            v_cnt  <= v_nxt;
            scan_r <= scan_nxt;
            if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

`ifdef VGA_SYNC_ALIGN_EN
   scan_sig_t scan_dly;

   sync_delay_line #(
      .WIDTH   ($bits(scan_sig_t)),
      .DEPTH   (PIPE_LAT),
      .RST_VAL (SCAN_IDLE)
   ) u_sync_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_tick),
      .d     (scan_r),
      .q     (scan_dly)
   );

   assign valid = scan_dly.valid;
   assign hsync = scan_dly.hsync;
   assign vsync = scan_dly.vsync;
`else
   assign valid = scan_r.valid;
   assign hsync = scan_r.hsync;
   assign vsync = scan_r.vsync;
`endif

endmodule

// File: tb/tb_vga_scan_gen.sv
// Directed bench for vga_scan_gen: full-size timing at CLK_DIV 1 and 4, plus a
// shrunken raster so frame strobes and frame_cnt wrap are reachable in a short run.
module tb_vga_scan_gen;

`ifdef VGA_SYNC_ALIGN_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 0;
`endif
   localparam bit LZ = (LAT == 0);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n, rst_bc_n;

   logic       tick_a, valid_a, hs_a, vs_a, ls_a, fs_a;
   logic [9:0] h_a, v_a;
   logic [7:0] fc_a;
   logic       tick_b, valid_b, hs_b, vs_b, ls_b, fs_b;
   logic [9:0] h_b, v_b;
   logic [7:0] fc_b;
   logic       tick_c, valid_c, hs_c, vs_c, ls_c, fs_c;
   logic [9:0] h_c, v_c;
   logic [7:0] fc_c;

   vga_scan_gen #(.CLK_DIV(1)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .pix_tick(tick_a), .h_cnt(h_a), .v_cnt(v_a),
      .valid(valid_a), .hsync(hs_a), .vsync(vs_a), .line_start(ls_a),
      .frame_start(fs_a), .frame_cnt(fc_a));

   // 16 x 8 raster: hsync low for h in [10,13), vsync low for v in [5,7), 128 ticks per frame.
   vga_scan_gen #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                  .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
      .clk(clk), .rst_n(rst_bc_n), .pix_tick(tick_b), .h_cnt(h_b), .v_cnt(v_b),
      .valid(valid_b), .hsync(hs_b), .vsync(vs_b), .line_start(ls_b),
      .frame_start(fs_b), .frame_cnt(fc_b));

   vga_scan_gen #(.CLK_DIV(4)) dut_c (
      .clk(clk), .rst_n(rst_bc_n), .pix_tick(tick_c), .h_cnt(h_c), .v_cnt(v_c),
      .valid(valid_c), .hsync(hs_c), .vsync(vs_c), .line_start(ls_c),
      .frame_start(fs_c), .frame_cnt(fc_c));

   int cyc_a = 0, cyc_bc = 0;
   int ls_cnt_a = 0, fs_cnt_a = 0, fs_cnt_b = 0, ls_cnt_c = 0;

   always @(posedge clk) begin
      cyc_a  <= rst_a_n  ? cyc_a + 1  : 0;
      cyc_bc <= rst_bc_n ? cyc_bc + 1 : 0;
   end

   always @(negedge clk) begin
      if (rst_a_n && ls_a)  ls_cnt_a <= ls_cnt_a + 1;
      if (rst_a_n && fs_a)  fs_cnt_a <= fs_cnt_a + 1;
      if (rst_bc_n && fs_b) fs_cnt_b <= fs_cnt_b + 1;
      if (rst_bc_n && ls_c) ls_cnt_c <= ls_cnt_c + 1;
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   typedef struct {
      int t;
      int dut;
      int h;
      int v;
      bit tick;
      bit ls;
      bit fs;
      int fc;
      bit chk_out;
      bit valid;
      bit hs;
      bit vs;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input int t, input int d, input int h, input int v,
                               input bit tk, input bit ls, input bit fs, input int fc,
                               input bit co, input bit vl, input bit hs, input bit vs);
      vec_t e;
      e.t = t; e.dut = d; e.h = h; e.v = v; e.tick = tk; e.ls = ls; e.fs = fs;
      e.fc = fc; e.chk_out = co; e.valid = vl; e.hs = hs; e.vs = vs;
      tbl.push_back(e);
   endfunction

   task automatic check_vec(input vec_t e);
      string      p;
      logic [9:0] h, v;
      logic       tk, vl, hs, vs, ls, fs;
      logic [7:0] fc;
      p = $sformatf("t%0d_dut%0d", e.t, e.dut);
      case (e.dut)
         0:       begin h = h_a; v = v_a; tk = tick_a; vl = valid_a; hs = hs_a; vs = vs_a; ls = ls_a; fs = fs_a; fc = fc_a; end
         1:       begin h = h_b; v = v_b; tk = tick_b; vl = valid_b; hs = hs_b; vs = vs_b; ls = ls_b; fs = fs_b; fc = fc_b; end
         default: begin h = h_c; v = v_c; tk = tick_c; vl = valid_c; hs = hs_c; vs = vs_c; ls = ls_c; fs = fs_c; fc = fc_c; end
      endcase
      chk({p, ".h_cnt"}, int'(h), e.h);
      chk({p, ".v_cnt"}, int'(v), e.v);
      chk({p, ".pix_tick"}, int'(tk), int'(e.tick));
      chk({p, ".line_start"}, int'(ls), int'(e.ls));
      chk({p, ".frame_start"}, int'(fs), int'(e.fs));
      chk({p, ".frame_cnt"}, int'(fc), e.fc);
      if (e.chk_out) begin
         chk({p, ".valid"}, int'(vl), int'(e.valid));
         chk({p, ".hsync"}, int'(hs), int'(e.hs));
         chk({p, ".vsync"}, int'(vs), int'(e.vs));
      end
   endtask

   task automatic wait_bc(input int t);
      while (cyc_bc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_a(input int t);
      while (cyc_a < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      rst_a_n  = 1'b0;
      rst_bc_n = 1'b0;

      // dut 0: full timing, CLK_DIV=1
      add(1,         0, 1,         0, 1, 0, 0, 0, 1, LZ, 1, 1);
      add(LAT + 1,   0, LAT + 1,   0, 1, 0, 0, 0, 1, 1,  1, 1);
      add(639 + LAT, 0, 639 + LAT, 0, 1, 0, 0, 0, 1, 1,  1, 1);
      add(640 + LAT, 0, 640 + LAT, 0, 1, 0, 0, 0, 1, 0,  1, 1);
      add(655 + LAT, 0, 655 + LAT, 0, 1, 0, 0, 0, 1, 0,  1, 1);
      add(656 + LAT, 0, 656 + LAT, 0, 1, 0, 0, 0, 1, 0,  0, 1);
      add(751 + LAT, 0, 751 + LAT, 0, 1, 0, 0, 0, 1, 0,  0, 1);
      add(752 + LAT, 0, 752 + LAT, 0, 1, 0, 0, 0, 1, 0,  1, 1);
      add(799,       0, 799,       0, 1, 0, 0, 0, 1, 0,  1, 1);
      add(800,       0, 0,         1, 1, 1, 0, 0, 1, LZ, 1, 1);
      add(801,       0, 1,         1, 1, 0, 0, 0, 0, 0,  1, 1);
      add(801 + LAT, 0, 1 + LAT,   1, 1, 0, 0, 0, 1, 1,  1, 1);
      // dut 1: 16x8 raster, CLK_DIV=1
      add(7 + LAT,   1, 7 + LAT,          0,               1, 0,  0, 0, 1, 1, 1, 1);
      add(8 + LAT,   1, 8 + LAT,          0,               1, 0,  0, 0, 1, 0, 1, 1);
      add(10 + LAT,  1, (10 + LAT) % 16,  (10 + LAT) / 16, 1, 0,  0, 0, 1, 0, 0, 1);
      add(79 + LAT,  1, (79 + LAT) % 16,  (79 + LAT) / 16, 1, 0,  0, 0, 1, 0, 1, 1);
      add(80 + LAT,  1, (80 + LAT) % 16,  (80 + LAT) / 16, 1, LZ, 0, 0, 1, 0, 1, 0);
      add(111 + LAT, 1, (111 + LAT) % 16, (111 + LAT) / 16, 1, 0, 0, 0, 1, 0, 1, 0);
      add(112 + LAT, 1, (112 + LAT) % 16, (112 + LAT) / 16, 1, LZ, 0, 0, 1, 0, 1, 1);
      add(127,   1, 15, 7, 1, 0, 0, 0,   0, 0, 0, 0);
      add(128,   1, 0,  0, 1, 1, 1, 1,   0, 0, 0, 0);
      add(129,   1, 1,  0, 1, 0, 0, 1,   0, 0, 0, 0);
      add(256,   1, 0,  0, 1, 1, 1, 2,   0, 0, 0, 0);
      add(32640, 1, 0,  0, 1, 1, 1, 255, 0, 0, 0, 0);
      add(32641, 1, 1,  0, 1, 0, 0, 255, 0, 0, 0, 0);
      add(32768, 1, 0,  0, 1, 1, 1, 0,   0, 0, 0, 0);
      // dut 2: full timing, CLK_DIV=4
      add(1,    2, 0,   0, 0, 0, 0, 0, 1, 0, 1, 1);
      add(3,    2, 0,   0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(4,    2, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(7,    2, 1,   0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(8,    2, 2,   0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(3199, 2, 799, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(3200, 2, 0,   1, 0, 1, 0, 0, 0, 0, 0, 0);
      add(3201, 2, 0,   1, 0, 0, 0, 0, 0, 0, 0, 0);
      add(6400, 2, 0,   2, 0, 1, 0, 0, 0, 0, 0, 0);

      repeat (5) @(posedge clk);
      #1;
      chk("rst.h_cnt",       int'(h_a),     0);
      chk("rst.v_cnt",       int'(v_a),     0);
      chk("rst.valid",       int'(valid_a), 0);
      chk("rst.hsync",       int'(hs_a),    1);
      chk("rst.vsync",       int'(vs_a),    1);
      chk("rst.line_start",  int'(ls_a),    0);
      chk("rst.frame_start", int'(fs_a),    0);
      chk("rst.frame_cnt",   int'(fc_a),    0);
      chk("rst.pix_tick_div1", int'(tick_a), 1);
      chk("rst.pix_tick_div4", int'(tick_c), 0);

      @(negedge clk);
      rst_a_n  = 1'b1;
      rst_bc_n = 1'b1;

      for (int t = 1; t <= 32768; t++) begin
         wait_bc(t);
         foreach (tbl[i]) if (tbl[i].t == t) check_vec(tbl[i]);
      end

      @(negedge clk);
      #1;
      chk("frames_counted_b",     fs_cnt_b, 256);
      chk("lines_counted_a",      ls_cnt_a, 40);
      chk("lines_counted_c",      ls_cnt_c, 10);
      chk("no_frame_start_a",     fs_cnt_a, 0);

      // Asynchronous reset in the middle of a frame, between clock edges.
      wait_a(40300);
      chk("mid.h_before", int'(h_a), 300);
      chk("mid.v_before", int'(v_a), 50);
      #2;
      rst_a_n = 1'b0;
      #1;
      chk("mid.h_cnt",      int'(h_a),     0);
      chk("mid.v_cnt",      int'(v_a),     0);
      chk("mid.valid",      int'(valid_a), 0);
      chk("mid.hsync",      int'(hs_a),    1);
      chk("mid.vsync",      int'(vs_a),    1);
      chk("mid.line_start", int'(ls_a),    0);
      chk("mid.frame_cnt",  int'(fc_a),    0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_a_n = 1'b1;
      wait_a(1);
      chk("rel.h_cnt",       int'(h_a),  1);
      chk("rel.v_cnt",       int'(v_a),  0);
      chk("rel.frame_start", int'(fs_a), 0);
      wait_a(800);
      chk("rel.line_h",      int'(h_a),  0);
      chk("rel.line_v",      int'(v_a),  1);
      chk("rel.line_start",  int'(ls_a), 1);
      chk("rel.frame_start", int'(fs_a), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
